// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - in-order load/store unit: issue FIFO, one memory transaction at a time, load writeback
// Optional response timeout enabled by defining CORE_LSU_TIMEOUT_EN.
module core_lsu #(
    parameter int WIDTH       = 32,
    parameter int REGS_CODING = 3,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   issue_wren,
    input  logic [WIDTH-1:0]       issue_addr,
    input  logic [WIDTH-1:0]       issue_wdata,
    input  logic [REGS_CODING-1:0] issue_dest,
    output logic                   request,
    output logic                   wren,
    output logic [WIDTH-1:0]       address,
    output logic [WIDTH-1:0]       writedata,
    input  logic                   response,
    input  logic [WIDTH-1:0]       readdata,
    output logic                   wb_valid,
    output logic [REGS_CODING-1:0] wb_dest,
    output logic [WIDTH-1:0]       wb_data,
    output logic                   busy,
    output logic                   err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, TURN} state_t;

    state_t                 state;
    logic                   q_wren  [DEPTH];
    logic [WIDTH-1:0]       q_addr  [DEPTH];
    logic [WIDTH-1:0]       q_wdata [DEPTH];
    logic [REGS_CODING-1:0] q_dest  [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [REGS_CODING-1:0] cur_dest;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign issue_ready = !full;
    assign push        = issue_valid && !full;
    // Popping from TURN as well keeps the request gap to the single turnaround cycle.
    assign pop         = (count != '0) && (state == IDLE || state == TURN);
    assign busy        = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_wren[wr_ptr]  <= issue_wren;
            q_addr[wr_ptr]  <= issue_addr;
            q_wdata[wr_ptr] <= issue_wdata;
            q_dest[wr_ptr]  <= issue_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CORE_LSU_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_r;
    assign err = err_r;
`else
    assign err = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            request   <= 1'b0;
            wren      <= 1'b0;
            address   <= '0;
            writedata <= '0;
            cur_dest  <= '0;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
`ifdef CORE_LSU_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (pop) begin
                        request   <= 1'b1;
                        wren      <= q_wren[rd_ptr];
                        address   <= q_addr[rd_ptr];
                        writedata <= q_wdata[rd_ptr];
                        cur_dest  <= q_dest[rd_ptr];
`ifdef CORE_LSU_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        state     <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (response) begin
                        request <= 1'b0;
                        state   <= TURN;
                        if (!wren) begin
                            wb_valid <= 1'b1;
                            wb_dest  <= cur_dest;
                            wb_data  <= readdata;
                        end
`ifdef CORE_LSU_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Abandoned loads still retire so the core does not stall on the register.
                        request <= 1'b0;
                        state   <= TURN;
                        err_r   <= 1'b1;
                        if (!wren) begin
                            wb_valid <= 1'b1;
                            wb_dest  <= cur_dest;
                            wb_data  <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// tb/tb_core_lsu.sv - directed self-checking bench for core_lsu
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_wren;
    logic [31:0] issue_addr;
    logic [31:0] issue_wdata;
    logic [2:0]  issue_dest;
    logic        request;
    logic        wren;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        response;
    logic [31:0] readdata;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    int passed = 0;
    int total  = 0;

    core_lsu #(.WIDTH(32), .REGS_CODING(3), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wren(issue_wren),
        .issue_addr(issue_addr), .issue_wdata(issue_wdata), .issue_dest(issue_dest),
        .request(request), .wren(wren), .address(address), .writedata(writedata),
        .response(response), .readdata(readdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] r);
        issue_valid = 1'b1;
        issue_wren  = w;
        issue_addr  = a;
        issue_wdata = d;
        issue_dest  = r;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; issue_valid = 1'b0; issue_wren = 1'b0; issue_addr = '0;
        issue_wdata = '0; issue_dest = '0; response = 1'b0; readdata = '0;
        repeat (2) @(negedge clk);
        total++; if (request !== 1'b0) $display("FAIL reset_request got=%0h exp=0", request); else passed++;
        total++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready got=%0h exp=1", issue_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else passed++;
        total++; if (wb_valid !== 1'b0 || err !== 1'b0) $display("FAIL reset_wb_err got=%0h%0h exp=00", wb_valid, err); else passed++;
        total++; if (address !== 32'h0 || wb_data !== 32'h0 || wb_dest !== 3'd0) $display("FAIL reset_data got=%h/%h/%0d exp=0", address, wb_data, wb_dest); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        issue(1'b0, 32'h10, 32'h0, 3'd3);
        @(negedge clk);
        issue_valid = 1'b0;
        total++; if (request !== 1'b0) $display("FAIL load_latency_early got=%0h exp=0", request); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL load_busy_queued got=%0h exp=1", busy); else passed++;
        @(negedge clk);
        total++; if (request !== 1'b1 || wren !== 1'b0 || address !== 32'h10) $display("FAIL load_request got=%0h/%0h/%h exp=1/0/00000010", request, wren, address); else passed++;
        @(negedge clk);
        total++; if (request !== 1'b1 || address !== 32'h10) $display("FAIL load_hold got=%0h/%h exp=1/00000010", request, address); else passed++;
        response = 1'b1; readdata = 32'hDEADBEEF;
        @(negedge clk);
        response = 1'b0; readdata = 32'h0;
        total++; if (wb_valid !== 1'b1 || wb_dest !== 3'd3 || wb_data !== 32'hDEADBEEF) $display("FAIL load_wb got=%0h/%0d/%h exp=1/3/deadbeef", wb_valid, wb_dest, wb_data); else passed++;
        total++; if (request !== 1'b0 || busy !== 1'b1) $display("FAIL load_turn got=%0h/%0h exp=0/1", request, busy); else passed++;
        @(negedge clk);
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL load_done got=%0h/%0h exp=0/0", wb_valid, busy); else passed++;
    endtask

    task automatic test_store;
        issue(1'b1, 32'h20, 32'h12345678, 3'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        total++; if (request !== 1'b1 || wren !== 1'b1 || address !== 32'h20 || writedata !== 32'h12345678)
            $display("FAIL store_request got=%0h/%0h/%h/%h exp=1/1/00000020/12345678", request, wren, address, writedata); else passed++;
        response = 1'b1; readdata = 32'hFFFFFFFF;
        @(negedge clk);
        response = 1'b0;
        total++; if (wb_valid !== 1'b0 || request !== 1'b0) $display("FAIL store_no_wb got=%0h/%0h exp=0/0", wb_valid, request); else passed++;
        @(negedge clk);
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL store_done got=%0h/%0h exp=0/0", wb_valid, busy); else passed++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                total++; if (issue_ready !== 1'b1) $display("FAIL b2b_ready_before_full got=%0h exp=1", issue_ready); else passed++;
            end
            issue(1'b0, 32'h100 + i, 32'h0, 3'(i));
            @(negedge clk);
        end
        total++; if (issue_ready !== 1'b0) $display("FAIL b2b_full got=%0h exp=0", issue_ready); else passed++;
        issue(1'b0, 32'h1FF, 32'h0, 3'd7);
        @(negedge clk);
        issue_valid = 1'b0;
        total++; if (issue_ready !== 1'b0) $display("FAIL b2b_full_hold got=%0h exp=0", issue_ready); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++; if (request !== 1'b1 || address !== 32'h100 + i) $display("FAIL b2b_order_%0d got=%0h/%h exp=1/%h", i, request, address, 32'h100 + i); else passed++;
            response = 1'b1; readdata = 32'hA0000000 + i;
            @(negedge clk);
            response = 1'b0;
            total++; if (wb_valid !== 1'b1 || wb_dest !== 3'(i) || wb_data !== 32'hA0000000 + i || request !== 1'b0)
                $display("FAIL b2b_wb_%0d got=%0h/%0d/%h/%0h exp=1/%0d/%h/0", i, wb_valid, wb_dest, wb_data, request, i, 32'hA0000000 + i); else passed++;
            if (i == 0) begin
                total++; if (issue_ready !== 1'b0) $display("FAIL b2b_full_turn got=%0h exp=0", issue_ready); else passed++;
            end
            @(negedge clk);
            if (i == 0) begin
                total++; if (issue_ready !== 1'b1) $display("FAIL b2b_ready_after_pop got=%0h exp=1", issue_ready); else passed++;
            end
            if (i < 4) begin
                total++; if (request !== 1'b1) $display("FAIL b2b_gap_%0d got=%0h exp=1", i, request); else passed++;
            end else begin
                total++; if (request !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) $display("FAIL b2b_end got=%0h/%0h/%0h exp=0/0/0", request, busy, wb_valid); else passed++;
            end
        end
        @(negedge clk);
        total++; if (request !== 1'b0) $display("FAIL b2b_overflow_dropped got=%0h exp=0", request); else passed++;
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 32'h40, 32'h1, 3'd0);
        @(negedge clk);
        issue(1'b1, 32'h44, 32'h2, 3'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        total++; if (request !== 1'b1) $display("FAIL rstmid_active got=%0h exp=1", request); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (request !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rstmid_async got=%0h/%0h/%0h exp=0/0/0", request, busy, wb_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        response = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if (request !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rstmid_lost got=%0h/%0h/%0h exp=0/0/0", request, busy, wb_valid); else passed++;
        end
        response = 1'b0;
    endtask

`ifdef CORE_LSU_TIMEOUT_EN
    task automatic test_timeout;
        int high = 0;
        issue(1'b0, 32'h80, 32'h0, 3'd5);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20 && request === 1'b1; k++) begin
            high++;
            @(negedge clk);
        end
        total++; if (high != 8) $display("FAIL tmo_cycles got=%0d exp=8", high); else passed++;
        total++; if (request !== 1'b0 || err !== 1'b1) $display("FAIL tmo_drop got=%0h/%0h exp=0/1", request, err); else passed++;
        total++; if (wb_valid !== 1'b1 || wb_dest !== 3'd5 || wb_data !== 32'h0) $display("FAIL tmo_wb got=%0h/%0d/%h exp=1/5/0", wb_valid, wb_dest, wb_data); else passed++;
        @(negedge clk);
        issue(1'b1, 32'h84, 32'h55, 3'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        total++; if (request !== 1'b1 || wren !== 1'b1 || address !== 32'h84) $display("FAIL tmo_next_req got=%0h/%0h/%h exp=1/1/00000084", request, wren, address); else passed++;
        response = 1'b1;
        @(negedge clk);
        response = 1'b0;
        total++; if (request !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b1) $display("FAIL tmo_next_done got=%0h/%0h/%0h exp=0/0/1", request, wb_valid, err); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || err !== 1'b1) $display("FAIL tmo_sticky got=%0h/%0h exp=0/1", busy, err); else passed++;
    endtask
`else
    task automatic test_no_timeout;
        issue(1'b0, 32'h90, 32'h0, 3'd6);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (300) @(negedge clk);
        total++; if (request !== 1'b1 || err !== 1'b0) $display("FAIL notmo_wait got=%0h/%0h exp=1/0", request, err); else passed++;
        response = 1'b1; readdata = 32'h00C0FFEE;
        @(negedge clk);
        response = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_dest !== 3'd6 || wb_data !== 32'h00C0FFEE) $display("FAIL notmo_wb got=%0h/%0d/%h exp=1/6/00c0ffee", wb_valid, wb_dest, wb_data); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL notmo_end got=%0h/%0h exp=0/0", busy, err); else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_store;
        test_back_to_back;
        test_reset_mid;
`ifdef CORE_LSU_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
